pht_update_scheduler: RTL

PHT_UPDATE_SCHEDULER -- requirements
Module: pht_update_scheduler

---
 rtl/gshare_pkg.sv | 16 +
 rtl/pht_update_fifo.sv | 63 ++++++
 rtl/pht_update_scheduler.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gshare_pkg.sv
// Shared types for the gshare pattern-history-table update path:
// 2-bit saturating counter type, its limits, and the RMW scheduler states.
package gshare_pkg;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_MAX = 2'd3;
   localparam ctr_t CTR_MIN = 2'd0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPD_RD = 2'd1,
      UPD_WR = 2'd2
   } state_t;

endpackage

// File: rtl/pht_update_fifo.sv
// Pending-update queue for the PHT scheduler: stores {index, taken} in
// acceptance order and reports its occupancy. DEPTH must be a power of two.
module pht_update_fifo
   import gshare_pkg::*;
#(
   parameter int INDEX_BITS = 13,
   parameter int DEPTH      = 4,
   localparam int PTR_W     = $clog2(DEPTH),
   localparam int CNT_W     = PTR_W + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [INDEX_BITS-1:0] push_index,
   input  logic                  push_taken,
   input  logic                  pop,
   output logic [INDEX_BITS-1:0] head_index,
   output logic                  head_taken,
   output logic [CNT_W-1:0]      count,
   output logic                  full,
   output logic                  empty
);

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [INDEX_BITS:0] slots [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;

   assign full       = (count == FULL_CNT);
   assign empty      = (count == '0);
   assign head_index = slots[rd_ptr][INDEX_BITS:1];
   assign head_taken = slots[rd_ptr][0];

   // Payload storage carries no reset; only occupancy is control state.
   always_ff @(posedge clk) begin
      if (push) begin
         slots[wr_ptr] <= {push_index, push_taken};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pht_update_scheduler.sv
// Arbitrates a single-port PHT RAM between gshare lookups (absolute priority)
// and queued read-modify-write counter updates. Optional PHT_UPD_BYPASS_EN
// forwards a stalled write's new counter MSB to a colliding lookup.
module pht_update_scheduler
   import gshare_pkg::*;
#(
   parameter int ENTRY_NUM   = 8192,
   parameter int INDEX_BITS  = $clog2(ENTRY_NUM),
   parameter int QUEUE_DEPTH = 4,
   localparam int CNT_W      = $clog2(QUEUE_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  lookup_valid,
   input  logic [INDEX_BITS-1:0] lookup_index,
   output logic                  pred_valid,
   output logic                  pred_taken,
   input  logic                  upd_valid,
   output logic                  upd_ready,
   input  logic [INDEX_BITS-1:0] upd_index,
   input  logic                  upd_taken,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [INDEX_BITS-1:0] mem_addr,
   output logic [1:0]            mem_wdata,
   input  logic [1:0]            mem_rdata,
   output logic [CNT_W-1:0]      queue_count
);

   if (ENTRY_NUM > (1 << INDEX_BITS)) begin : g_bad_index_bits
      $error("ENTRY_NUM does not fit in INDEX_BITS");
   end
   if ((QUEUE_DEPTH < 2) || ((QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("QUEUE_DEPTH must be a power of two and at least 2");
   end

   function automatic ctr_t sat_step(input ctr_t ctr, input logic taken);
      if (taken) begin
         return (ctr == CTR_MAX) ? CTR_MAX : ctr_t'(ctr + ctr_t'(1));
      end
      return (ctr == CTR_MIN) ? CTR_MIN : ctr_t'(ctr - ctr_t'(1));
   endfunction

   state_t                state;
   state_t                state_nxt;
   ctr_t                  ctr_q;
   ctr_t                  ctr_upd;
   logic                  pred_valid_q;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  empty;
   logic [INDEX_BITS-1:0] head_index;
   logic                  head_taken;

   assign upd_ready = !full;
   assign push      = upd_valid && upd_ready;
   assign ctr_upd   = sat_step(ctr_q, head_taken);

   pht_update_fifo #(
      .INDEX_BITS (INDEX_BITS),
      .DEPTH      (QUEUE_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_index (upd_index),
      .push_taken (upd_taken),
      .pop        (pop),
      .head_index (head_index),
      .head_taken (head_taken),
      .count      (queue_count),
      .full       (full),
      .empty      (empty)
   );

   // The head entry stays in the queue until its write lands, so the head
   // index/outcome serve as the in-flight update's address and direction.
   always_comb begin
      state_nxt = state;
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = lookup_index;
      mem_wdata = ctr_upd;
      pop       = 1'b0;
      if (lookup_valid) begin
         mem_en = 1'b1;
         if (state == UPD_RD) begin
            state_nxt = UPD_WR;
         end
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  mem_en    = 1'b1;
                  mem_addr  = head_index;
                  state_nxt = UPD_RD;
               end
            end
            UPD_RD: begin
               state_nxt = UPD_WR;
            end
            UPD_WR: begin
               mem_en    = 1'b1;
               mem_we    = 1'b1;
               mem_addr  = head_index;
               pop       = 1'b1;
               state_nxt = IDLE;
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

   // UPD_RD always captures: the read data belongs to the read issued in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ctr_q        <= CTR_MIN;
         pred_valid_q <= 1'b0;
      end else begin
         state        <= state_nxt;
         pred_valid_q <= lookup_valid;
         if (state == UPD_RD) begin
            ctr_q <= ctr_t'(mem_rdata);
         end
      end
   end

   assign pred_valid = pred_valid_q;

`ifdef PHT_UPD_BYPASS_EN
   logic byp_hit_q;
   logic byp_taken_q;

   // A lookup colliding with the stalled write would otherwise see stale RAM data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byp_hit_q   <= 1'b0;
         byp_taken_q <= 1'b0;
      end else begin
         byp_hit_q   <= lookup_valid && (state == UPD_WR) && (lookup_index == head_index);
         byp_taken_q <= ctr_upd[1];
      end
   end

   assign pred_taken = pred_valid_q && (byp_hit_q ? byp_taken_q : mem_rdata[1]);
`else
   assign pred_taken = pred_valid_q && mem_rdata[1];
`endif

endmodule
